// File: rtl/fpa_pkg.sv
// Shared widths, stage payload and special-value builder for the pipelined FP adder.
package fpa_pkg;

    localparam int EXP_MAX = 15;                    // widest exponent field supported
    localparam int MAG_MAX = 64;                    // magnitude field, working value left-aligned in it
    localparam int XW      = EXP_MAX + 2;           // signed stage exponent (room for borrow/carry)
    localparam int W_MAX   = 1 + EXP_MAX + MAG_MAX; // upper bound on the word width

    typedef enum logic [1:0] {
        SP_ZERO = 2'd0,
        SP_INF  = 2'd1,
        SP_NAN  = 2'd2
    } spec_kind_t;

    // Payload carried between stages. mag holds {headroom, hidden, frac, G, R, S}
    // at the top of the field so S3 can normalise without knowing MAN_W offsets.
    typedef struct packed {
        logic                 sign;
        logic signed [XW-1:0] exp;
        logic [MAG_MAX-1:0]   mag;
        logic                 spec;
        spec_kind_t           kind;
    } stage_t;

    function automatic int fpa_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int fpa_ww(input int man_w);
        return man_w + 4;
    endfunction

    // Canonical qNaN (sign 0), signed inf or signed zero, right-aligned.
    function automatic logic [W_MAX-1:0] fpa_special(input spec_kind_t kind, input logic sign,
                                                     input int exp_w, input int man_w);
        logic [W_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < W_MAX; i++) begin
            if (kind != SP_ZERO && i >= man_w && i < man_w + exp_w) v[i] = 1'b1;
        end
        if (kind == SP_NAN) v[man_w-1] = 1'b1;
        else                v[exp_w+man_w] = sign;
        return v;
    endfunction

endpackage

// File: rtl/lzc.sv
// Leading-zero counter; an all-zero input returns N.
module lzc #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  d,
    output logic [CW-1:0] cnt
);

    // Scan upward so the most significant set bit wins.
    always_comb begin
        cnt = CW'(N);
        for (int i = 0; i < N; i++) begin
            if (d[i]) cnt = CW'(N - 1 - i);
        end
    end

endmodule

// File: rtl/fpa_pipe.sv
// Three-stage FP add/sub: S1 classify/align, S2 add, S3 normalise/round/pack.
module fpa_pipe import fpa_pkg::*; #(
    parameter int   EXP_W = 8,
    parameter int   MAN_W = 23,
    localparam int  W     = fpa_w(EXP_W, MAN_W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         of,
    output logic         uf
);

    localparam int WW   = fpa_ww(MAN_W);
    localparam int PADW = MAG_MAX - WW - 1;
    localparam int CW   = $clog2(MAG_MAX + 1);
    localparam logic [EXP_W-1:0]  EXP_ONES = '1;
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EONE = XW'(1);

    logic [3:1]         vld_pipe;
    logic               adv;
    stage_t             s1_d, s1_q, s2_d, s2_q;
    logic [MAG_MAX-1:0] y_d, s1_y;
    logic               sub_d, s1_sub;

    // S1 signals
    logic               sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap, y_zero;
    logic [EXP_W-1:0]   ea, eb, ex, ey, diff;
    logic [MAN_W-1:0]   fa, fb, fx, fy;
    logic [WW-1:0]      mx, my, y_sh, lost_mask;

    // S3 signals
    logic [CW-1:0]        lz;
    logic [MAG_MAX-1:0]   norm;
    logic [MAN_W:0]       mant;
    logic                 g, r, st, inc;
    logic [MAN_W+1:0]     mr;
    logic [MAN_W-1:0]     frac;
    logic signed [XW-1:0] e1, e2;
    logic [W-1:0]         sum_d;
    logic                 of_d, uf_d;

    assign adv       = !vld_pipe[3] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[3];

    // S1: flush subnormals, resolve specials, order by magnitude, align Y with sticky.
    always_comb begin
        sa     = a[W-1];
        sb     = b[W-1] ^ sub;
        ea     = a[W-2:MAN_W];
        eb     = b[W-2:MAN_W];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        fa     = a_zero ? '0 : a[MAN_W-1:0];
        fb     = b_zero ? '0 : b[MAN_W-1:0];
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        swap   = {eb, fb} > {ea, fa};
        ex     = swap ? eb : ea;
        ey     = swap ? ea : eb;
        fx     = swap ? fb : fa;
        fy     = swap ? fa : fb;
        y_zero = swap ? a_zero : b_zero;
        diff   = ex - ey;
        mx     = {1'b1, fx, 3'b000};
        my     = {!y_zero, fy, 3'b000};
        lost_mask = ~({WW{1'b1}} << diff);
        if (int'(diff) >= WW - 1) begin
            y_sh = {{(WW-1){1'b0}}, |my};
        end else begin
            y_sh    = my >> diff;
            y_sh[0] = y_sh[0] | (|(my & lost_mask));
        end

        sub_d     = sa ^ sb;
        y_d       = {1'b0, y_sh, {PADW{1'b0}}};
        s1_d      = '0;
        s1_d.sign = swap ? sb : sa;
        s1_d.exp  = {{(XW-EXP_W){1'b0}}, ex};
        s1_d.mag  = {1'b0, mx, {PADW{1'b0}}};
        if (a_nan | b_nan | (a_inf & b_inf & (sa != sb))) begin
            s1_d.spec = 1'b1;
            s1_d.kind = SP_NAN;
            s1_d.sign = 1'b0;
        end else if (a_inf) begin
            s1_d.spec = 1'b1;
            s1_d.kind = SP_INF;
            s1_d.sign = sa;
        end else if (b_inf) begin
            s1_d.spec = 1'b1;
            s1_d.kind = SP_INF;
            s1_d.sign = sb;
        end else if (a_zero & b_zero) begin
            s1_d.spec = 1'b1;
            s1_d.kind = SP_ZERO;
            s1_d.sign = sa & sb;
        end
    end

    // S2: X >= Y, so the subtract never goes negative; headroom bit catches the carry.
    always_comb begin
        s2_d     = s1_q;
        s2_d.mag = s1_sub ? (s1_q.mag - s1_y) : (s1_q.mag + s1_y);
    end

    lzc #(.N(MAG_MAX), .CW(CW)) u_lzc (
        .d   (s2_q.mag),
        .cnt (lz)
    );

    // S3: normalise to the top bit (a carry simply means lz == 0), round RNE, pack.
    always_comb begin
        norm  = s2_q.mag << lz;
        mant  = norm[MAG_MAX-1 -: MAN_W+1];
        g     = norm[MAG_MAX-MAN_W-2];
        r     = norm[MAG_MAX-MAN_W-3];
        st    = |norm[MAG_MAX-MAN_W-4:0];
        inc   = g & (r | st | mant[0]);
        mr    = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
        e1    = s2_q.exp + XW'(1) - XW'(lz);
        e2    = mr[MAN_W+1] ? e1 + XW'(1) : e1;
        frac  = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        sum_d = {s2_q.sign, e2[EXP_W-1:0], frac};
        of_d  = 1'b0;
        uf_d  = 1'b0;
        if (s2_q.spec) begin
            sum_d = W'(fpa_special(s2_q.kind, s2_q.sign, EXP_W, MAN_W));
        end else if (s2_q.mag == '0) begin
            sum_d = '0;
        end else if (e2 >= EMAX) begin
            sum_d = W'(fpa_special(SP_INF, s2_q.sign, EXP_W, MAN_W));
            of_d  = 1'b1;
        end else if (e2 < EONE) begin
            sum_d = W'(fpa_special(SP_ZERO, s2_q.sign, EXP_W, MAN_W));
            uf_d  = 1'b1;
        end
    end

    // Valid shift register: bubbles move like data, everything freezes on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      vld_pipe <= '0;
        else if (adv) vld_pipe <= {vld_pipe[2:1], in_valid};
    end

    // S1/S2 payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s1_y   <= '0;
            s1_sub <= 1'b0;
            s2_q   <= '0;
        end else if (adv) begin
            s1_q   <= s1_d;
            s1_y   <= y_d;
            s1_sub <= sub_d;
            s2_q   <= s2_d;
        end
    end

    // S3 output registers drive the ports directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            of  <= 1'b0;
            uf  <= 1'b0;
        end else if (adv) begin
            sum <= sum_d;
            of  <= of_d;
            uf  <= uf_d;
        end
    end

endmodule

// File: tb/tb_fpa_pipe.sv
// Directed-vector bench for fpa_pipe with a queue scoreboard and a separate output monitor.
module tb_fpa_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        of, uf;

    fpa_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .of        (of),
        .uf        (uf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        of;
        logic        uf;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic        of;
        logic        uf;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    task automatic addv(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                        input logic [31:0] res, input logic vof, input logic vuf, input string nm);
        vec_t v;
        v.a = va; v.b = vb; v.sub = vs; v.s = res; v.of = vof; v.uf = vuf; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Present vector i from posedge+1, wait for the handshake, push its expectation.
    task automatic send(input int i);
        int   guard = 0;
        logic acc = 1'b0;
        exp_t e;
        a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) begin
                @(posedge clk); #1;
            end
            guard++;
        end while (!acc && guard < 200);
        if (acc) begin
            e.s = vecs[i].s; e.of = vecs[i].of; e.uf = vecs[i].uf; e.name = vecs[i].name;
            q.push_back(e);
        end else begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout %s: in_ready stayed 0 for %0d cycles", vecs[i].name, guard);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk({"drain_", nm}, 32'(q.size()), 32'(0));
    endtask

    // Ready generator, updated just after each rising edge.
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: every retiring result is checked against the head of the queue.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got sum=%h with nothing outstanding", sum);
            end else begin
                e = q.pop_front();
                if ({sum, of, uf} !== {e.s, e.of, e.uf}) begin
                    n_fail++;
                    $display("FAIL %s: got sum=%h of=%b uf=%b want sum=%h of=%b uf=%b",
                             e.name, sum, of, uf, e.s, e.of, e.uf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        addv(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, "one_plus_one");   // 0
        addv(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, "one_minus_one");  // 1
        addv(32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 1'b0, 1'b0, "lzc_norm");       // 2
        addv(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, "tie_even");       // 3
        addv(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, "tie_odd");        // 4
        addv(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, "overflow");       // 5
        addv(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, "underflow");      // 6
        addv(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, "inf_minus_inf");  // 7
        addv(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, "nan_in");         // 8
        addv(32'hFF800000, 32'h40A00000, 1'b0, 32'hFF800000, 1'b0, 1'b0, "ninf_plus_5");    // 9
        addv(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, "neg_zeros");      // 10
        addv(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0, "mixed_zeros");    // 11
        addv(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, "neg_result");     // 12
        addv(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, "subnorm_flush");  // 13
        addv(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0, "round_up");       // 14
        addv(32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0, "inf_plus_inf");   // 15
        addv(32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 1'b1, 1'b0, "neg_overflow");   // 16
        addv(32'h3F800000, 32'h30000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, "far_sticky");     // 17
        addv(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 1'b0, 1'b0, "sub_borrow");     // 18
        addv(32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000, 1'b0, 1'b0, "sub_tie_up");     // 19

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum",       sum,             32'(0));
        chk("rst_of",        32'(of),        32'(0));
        chk("rst_uf",        32'(uf),        32'(0));
        rst = 1'b0;
        #1 chk("in_ready_after_rst", 32'(in_ready), 32'(1));
        @(posedge clk); #1;

        // Latency: accept edge is the first of three edges before out_valid
        send(0);
        @(negedge clk); chk("lat_edge1", 32'(out_valid), 32'(0));
        @(negedge clk); chk("lat_edge2", 32'(out_valid), 32'(0));
        @(negedge clk); chk("lat_edge3", 32'(out_valid), 32'(1));
        @(posedge clk); #1;

        // Directed table back-to-back
        for (int i = 1; i < vecs.size(); i++) send(i);
        drain("directed");

        // Stream with random backpressure and a 5-cycle stall
        @(posedge clk); #1;
        rdy_mode = 1;
        fork
            begin
                for (int k = 0; k < 20; k++) send((k * 7) % 20);
            end
            begin
                repeat (8) @(posedge clk);
                rdy_mode = 2;
                repeat (5) @(posedge clk);
                rdy_mode = 1;
            end
        join
        drain("stream");

        // Reset with pairs in flight
        send(5); send(6); send(7); send(9);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_sum",       sum,             32'(0));
        chk("midrst_of",        32'(of),        32'(0));
        chk("midrst_uf",        32'(uf),        32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("in_ready_after_midrst", 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        send(0); send(2); send(4); send(12); send(14); send(18);
        rdy_mode = 0;
        drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
